// File: rtl/led_pwm_driver.sv
// LED pin output stage: global PWM brightness with frame-aligned duty updates and optional per-bit blink.
// Optional blink logic is enabled by defining LED_BLINK_EN.
module led_pwm_driver #(
  parameter int unsigned LED_W        = 24,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PRESC_DIV    = 100,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] led_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_ld,
  input  logic [LED_W-1:0] blink_in,
  input  logic             blink_ld,
  output logic [LED_W-1:0] led_out,
  output logic             frame_tick
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [LED_W-1:0] led_q;
  logic [PW-1:0]    presc_cnt;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] duty_act;
  logic             step;
  logic             frame_end;
  logic             pwm_on;
  logic [LED_W-1:0] blink_gate;

  assign step      = (presc_cnt == PRESC_LAST);
  assign frame_end = step & (&pwm_cnt);
  // All-ones duty is forced on so full brightness has no dark step per frame.
  assign pwm_on    = (&duty_act) | (pwm_cnt < duty_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= '0;
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      duty_shadow <= '1;
      duty_act    <= '1;
      led_out     <= '0;
      frame_tick  <= 1'b0;
    end else begin
      led_q      <= led_in;
      frame_tick <= frame_end;
      led_out    <= led_q & {LED_W{pwm_on}} & blink_gate;
      presc_cnt  <= step ? '0 : presc_cnt + 1'b1;
      if (step)
        pwm_cnt <= pwm_cnt + 1'b1;
      if (duty_ld)
        duty_shadow <= duty_in;
      // A load landing on the wrap edge is forwarded straight into the active duty.
      if (frame_end)
        duty_act <= duty_ld ? duty_in : duty_shadow;
    end
  end

`ifdef LED_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [LED_W-1:0] blink_q;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;

  assign blink_gate = ~blink_q | {LED_W{blink_phase}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (blink_ld)
        blink_q <= blink_in;
      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink_in, blink_ld};
  assign blink_gate   = '1;
`endif

endmodule
